vga_fb_arbiter: RTL

Frame-buffer port scheduler between the VGA timing generator and the single-port pixel RAM. It shares one RAM port between display scan-out reads and a drawing-logic writer. Scan-out always wins on its slots, and the writer gets every other cycle plus all blanking time. It maps 640x480 screen coordinates onto a 320x240 buffer (2x2 pixel doubling) and delivers registered pixel data to the RGB output stage.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_fb_addr_gen.sv | 20 ++
 rtl/vga_fb_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared frame-buffer constants, pixel/bus payload types and writer FSM states
// for the VGA frame-buffer path.
package vga_pkg;

  localparam int unsigned FB_W      = 320;
  localparam int unsigned FB_H      = 240;
  localparam int unsigned FB_PIXELS = FB_W * FB_H;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned DATA_W    = 12;
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned XY_W      = CNT_W - 1;

  // RGB444 pixel
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  // One RAM port operation
  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } wr_state_e;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Buffer coordinate to linear RAM address: y*320 + x, built as y*256 + y*64 + x.
module vga_fb_addr_gen
  import vga_pkg::*;
(
  input  logic [XY_W-1:0]   i_x,
  input  logic [XY_W-1:0]   i_y,
  output logic [ADDR_W-1:0] o_addr_c
);

  logic [ADDR_W-1:0] w_y;
  logic [ADDR_W-1:0] w_x;

  assign w_y = ADDR_W'(i_y);
  assign w_x = ADDR_W'(i_x);

  always_comb begin
    o_addr_c = (w_y << 8) + (w_y << 6) + w_x;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares the single pixel-RAM port between 2x2-doubled scan-out reads (even
// active columns) and a drawing writer (all other cycles), with registered outputs.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              pclk,
  input  logic              reset,
  input  logic              valid,
  input  logic [CNT_W-1:0]  h_cnt,
  input  logic [CNT_W-1:0]  v_cnt,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_drop,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              frame_start
);

  wr_state_e         r_state;
  wr_state_e         w_state_nxt;
  mem_req_t          r_mem;
  mem_req_t          w_mem_nxt;
  logic              r_wr_ack;
  logic              w_wr_ack_nxt;
  logic              r_wr_drop;
  logic              w_wr_drop_nxt;
  logic              r_valid_d1;
  logic              r_pix_valid;
  logic              r_frame_start;
  pixel_t            r_pix;
  logic              w_disp_slot;
  logic              w_wr_in_range;
  logic              w_rd_live;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_disp_slot   = valid & ~h_cnt[0];
  assign w_wr_in_range = (wr_addr < ADDR_W'(FB_PIXELS));
  assign w_rd_live     = r_mem.en & ~r_mem.we;

  vga_fb_addr_gen u_addr_gen (
    .i_x      (h_cnt[CNT_W-1:1]),
    .i_y      (v_cnt[CNT_W-1:1]),
    .o_addr_c (w_rd_addr)
  );

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slot arbitration and writer sequencing; a display slot never grants the writer
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_nxt       = r_mem;
    w_mem_nxt.en    = 1'b0;
    w_mem_nxt.we    = 1'b0;
    w_wr_ack_nxt    = 1'b0;
    w_wr_drop_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (wr_req && !w_disp_slot) begin
          w_state_nxt = ISSUE;
          if (w_wr_in_range) begin
            w_mem_nxt.en    = 1'b1;
            w_mem_nxt.we    = 1'b1;
            w_mem_nxt.addr  = wr_addr;
            w_mem_nxt.wdata = wr_data;
          end
        end
      end
      ISSUE: begin
        w_state_nxt   = ACK;
        w_wr_ack_nxt  = 1'b1;
        w_wr_drop_nxt = ~w_wr_in_range;
      end
      ACK: begin
        // Held request is ignored here so it is not written twice
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_disp_slot) begin
      w_mem_nxt.en   = 1'b1;
      w_mem_nxt.we   = 1'b0;
      w_mem_nxt.addr = w_rd_addr;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_mem     <= '0;
      r_wr_ack  <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_mem     <= w_mem_nxt;
      r_wr_ack  <= w_wr_ack_nxt;
      r_wr_drop <= w_wr_drop_nxt;
    end
  end

  // Scan-out: capture read data once per even column, hold across the odd one
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_valid_d1    <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_pix         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_valid_d1    <= valid;
      r_pix_valid   <= r_valid_d1;
      r_frame_start <= valid && (h_cnt == '0) && (v_cnt == '0);
      if (!r_valid_d1) begin
        r_pix <= '0;
      end else if (w_rd_live) begin
        r_pix <= pixel_t'(mem_rdata);
      end
    end
  end

  assign wr_ack      = r_wr_ack;
  assign wr_drop     = r_wr_drop;
  assign mem_en      = r_mem.en;
  assign mem_we      = r_mem.we;
  assign mem_addr    = r_mem.addr;
  assign mem_wdata   = r_mem.wdata;
  assign pix_data    = r_pix;
  assign pix_valid   = r_pix_valid;
  assign frame_start = r_frame_start;

endmodule
